// File: rtl/wb_reg_slave.sv
// Wishbone classic single-access slave with a small register bank, programmable wait states
// and a registered level interrupt.
module wb_reg_slave #(
  parameter int unsigned             ADDR_WIDTH  = 32,
  parameter int unsigned             DATA_WIDTH  = 16,
  parameter int unsigned             NUM_REGS    = 8,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR   = '0,
  parameter int unsigned             WAIT_STATES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  irq_o
);

  localparam int unsigned OffW   = $clog2(NUM_REGS);
  localparam int unsigned NumScr = NUM_REGS - 4;

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  ack_q, irq_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  wr_en_q;
  logic [OffW-1:0]       wr_off_q;
  logic [DATA_WIDTH-1:0] wr_dat_q;

  logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [1:0]            stat_q, stat_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] scr_q [NumScr];
  logic [DATA_WIDTH-1:0] scr_d [NumScr];

  logic [ADDR_WIDTH-1:0] off_full;
  logic                  in_range;
  logic [OffW-1:0]       off;
  logic                  go, enter_ack;
  logic [DATA_WIDTH-1:0] rd_data;

  assign off_full = adr_i - BASE_ADDR;
  assign in_range = (adr_i >= BASE_ADDR) && (off_full < ADDR_WIDTH'(NUM_REGS));
  assign off      = off_full[OffW-1:0];
  assign go       = cyc_i & stb_i;

  // Address/data are sampled only on the edge that enters StAck.
  assign enter_ack = go && (((state_q == StIdle) && (WAIT_STATES == 0)) ||
                            ((state_q == StWait) && (cnt_q == 4'd0)));

  always_comb begin
    rd_data = '0;
    if (in_range) begin
      case (off)
        OffW'(0): rd_data = ctrl_q;
        OffW'(1): rd_data = {{(DATA_WIDTH-2){1'b0}}, stat_q};
        OffW'(3): rd_data = acc_q;
        default:  rd_data = '0;
      endcase
      for (int unsigned i = 0; i < NumScr; i++) begin
        if (off == OffW'(i + 4)) rd_data = scr_q[i];
      end
    end
  end

  // Register-bank updates happen only on the edge leaving StAck.
  always_comb begin
    ctrl_d = ctrl_q;
    stat_d = stat_q;
    acc_d  = acc_q;
    scr_d  = scr_q;
    if (state_q == StAck) begin
      acc_d = acc_q + DATA_WIDTH'(1);
      if (wr_en_q) begin
        case (wr_off_q)
          OffW'(0): ctrl_d = wr_dat_q;
          OffW'(1): stat_d = stat_q & ~wr_dat_q[1:0];
          OffW'(2): if (wr_dat_q[0]) stat_d[0] = 1'b1;
          default: ;
        endcase
        for (int unsigned i = 0; i < NumScr; i++) begin
          if (wr_off_q == OffW'(i + 4)) scr_d[i] = wr_dat_q;
        end
      end
      // Applied after the W1C so a same-edge wrap wins.
      if (acc_q == '1) stat_d[1] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      irq_q    <= 1'b0;
      dat_q    <= '0;
      wr_en_q  <= 1'b0;
      wr_off_q <= '0;
      wr_dat_q <= '0;
      ctrl_q   <= '0;
      stat_q   <= '0;
      acc_q    <= '0;
      scr_q    <= '{default: '0};
    end else begin
      ack_q  <= enter_ack;
      irq_q  <= ctrl_q[0] & (|stat_q);
      ctrl_q <= ctrl_d;
      stat_q <= stat_d;
      acc_q  <= acc_d;
      scr_q  <= scr_d;
      if (enter_ack) begin
        wr_en_q  <= we_i & in_range;
        wr_off_q <= off;
        wr_dat_q <= dat_i;
        if (!we_i) dat_q <= rd_data;
      end
      case (state_q)
        StIdle: begin
          if (go) begin
            if (WAIT_STATES == 0) begin
              state_q <= StAck;
            end else begin
              state_q <= StWait;
              cnt_q   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        StWait: begin
          if (!go)                  state_q <= StIdle;
          else if (cnt_q == 4'd0)   state_q <= StAck;
          else                      cnt_q   <= cnt_q - 4'd1;
        end
        StAck:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack_o = ack_q;
  assign dat_o = dat_q;
  assign irq_o = irq_q;

endmodule

// File: tb/tb_wb_reg_slave.sv
// Self-checking bench for wb_reg_slave: three instances (0, 1 and 3 wait states) driven by
// directed tables, corner-case sequences and random traffic against a functional model.
module tb_wb_reg_slave;

  localparam int Base = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  cyc = '0;
  logic [2:0]  stb = '0;
  logic        we = 1'b0;
  logic [31:0] adr = '0;
  logic [15:0] wdat = '0;
  wire  [2:0]  ack;
  wire  [2:0]  irq;
  wire  [7:0]  do0;
  wire  [15:0] do1, do2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(8), .NUM_REGS(8), .BASE_ADDR(32'd16),
                 .WAIT_STATES(0)) u0 (
    .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we), .adr_i(adr),
    .dat_i(wdat[7:0]), .ack_o(ack[0]), .dat_o(do0), .irq_o(irq[0]));

  wb_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(16), .NUM_REGS(8), .BASE_ADDR(32'd16),
                 .WAIT_STATES(1)) u1 (
    .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we), .adr_i(adr),
    .dat_i(wdat), .ack_o(ack[1]), .dat_o(do1), .irq_o(irq[1]));

  wb_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(16), .NUM_REGS(8), .BASE_ADDR(32'd16),
                 .WAIT_STATES(3)) u3 (
    .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we), .adr_i(adr),
    .dat_i(wdat), .ack_o(ack[2]), .dat_o(do2), .irq_o(irq[2]));

  // Functional model: one register image per instance.
  int ws[3]   = '{0, 1, 3};
  int mask[3] = '{32'hFF, 32'hFFFF, 32'hFFFF};
  int m_reg[3][8];
  int m_stat[3];
  int m_cnt[3];
  int m_last[3];

  typedef struct {
    bit w;
    int off;
    int d;
    int exp;
    int irq;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic int rd_of(input int k);
    case (k)
      0:       return int'(do0);
      1:       return int'(do1);
      default: return int'(do2);
    endcase
  endfunction

  function automatic int model_irq(input int k);
    return ((m_reg[k][0] & 1) != 0 && m_stat[k] != 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 8; r++) m_reg[k][r] = 0;
      m_stat[k] = 0;
      m_cnt[k]  = 0;
      m_last[k] = 0;
    end
  endtask

  task automatic model_apply(input int k, input bit w, input int off, input int d,
                             output int exp);
    bit inr;
    int dm;
    inr = (off >= 0) && (off < 8);
    dm  = d & mask[k];
    if (!w) begin
      exp = 0;
      if (inr) begin
        case (off)
          1:       exp = m_stat[k];
          2:       exp = 0;
          3:       exp = m_cnt[k];
          default: exp = m_reg[k][off];
        endcase
      end
      m_last[k] = exp;
    end else begin
      exp = m_last[k];
      if (inr) begin
        case (off)
          1:       m_stat[k] = m_stat[k] & ~(dm & 3);
          2:       if ((dm & 1) != 0) m_stat[k] = m_stat[k] | 1;
          3:       ;
          default: m_reg[k][off] = dm;
        endcase
      end
    end
    m_cnt[k] = (m_cnt[k] + 1) & mask[k];
    if (m_cnt[k] == 0) m_stat[k] = m_stat[k] | 2;
  endtask

  // One complete access; checks latency, data, ack width and irq two cycles later.
  task automatic xact(input int k, input bit w, input int off, input int d, output int rd);
    int lat;
    int exp;
    adr  = 32'(Base + off);
    wdat = 16'(d);
    we   = w;
    cyc[k] = 1'b1;
    stb[k] = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (ack[k] !== 1'b1 && lat < 40);
    check("ack_latency", lat, ws[k] + 1);
    rd = rd_of(k);
    cyc[k] = 1'b0;
    stb[k] = 1'b0;
    we     = 1'b0;
    model_apply(k, w, off, d, exp);
    check(w ? "dat_o_hold" : "read_data", rd, exp);
    @(posedge clk);
    #1;
    check("ack_width", int'(ack[k]), 0);
    @(posedge clk);
    #1;
    check("irq", int'(irq[k]), model_irq(k));
  endtask

  task automatic rand_run(input int k, input int n);
    int rd;
    for (int i = 0; i < n; i++) begin
      xact(k, 1'($urandom_range(1, 0)), int'($urandom_range(11, 0)) - 2,
           int'($urandom_range(16'hFFFF, 0)), rd);
    end
  endtask

  initial begin
    int rd;
    int lat;
    int guard;

    tbl[0]  = '{1'b1, 4, 16'h0005, 0, 0};
    tbl[1]  = '{1'b0, 4, 0, 16'h0005, 0};
    tbl[2]  = '{1'b1, 0, 16'h0001, 0, 0};
    tbl[3]  = '{1'b1, 2, 16'h0001, 0, 1};
    tbl[4]  = '{1'b0, 1, 0, 16'h0001, 1};
    tbl[5]  = '{1'b1, 1, 16'h0001, 0, 0};
    tbl[6]  = '{1'b0, 3, 0, 6, 0};
    tbl[7]  = '{1'b1, 8, 16'hABCD, 0, 0};
    tbl[8]  = '{1'b0, 8, 0, 0, 0};
    tbl[9]  = '{1'b1, -1, 16'h1234, 0, 0};
    tbl[10] = '{1'b0, 0, 0, 16'h0001, 0};
    tbl[11] = '{1'b0, 2, 0, 0, 0};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("reset_ack", int'(ack[k]), 0);
      check("reset_dat", rd_of(k), 0);
      check("reset_irq", int'(irq[k]), 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table on the one-wait-state instance.
    for (int i = 0; i < 12; i++) begin
      xact(1, tbl[i].w, tbl[i].off, tbl[i].d, rd);
      if (!tbl[i].w) check("tbl_read", rd, tbl[i].exp);
      check("tbl_irq", int'(irq[1]), tbl[i].irq);
    end

    rand_run(1, 300);
    rand_run(0, 100);
    rand_run(2, 60);

    // ACC_CNT wrap on the 8-bit instance.
    xact(0, 1'b1, 0, 1, rd);
    xact(0, 1'b1, 1, 3, rd);
    guard = 0;
    while (m_cnt[0] != 255 && guard < 300) begin
      xact(0, 1'b0, 5, 0, rd);
      guard++;
    end
    xact(0, 1'b0, 3, 0, rd);
    check("wrap_pre_value", rd, 255);
    check("wrap_irq", int'(irq[0]), 1);
    xact(0, 1'b0, 1, 0, rd);
    check("wrap_stat", rd & 2, 2);

    // Abort during WAIT: no ack, no write, no count.
    xact(2, 1'b1, 4, 16'h00AA, rd);
    adr = 32'(Base + 4); wdat = 16'h1234; we = 1'b1; cyc[2] = 1'b1; stb[2] = 1'b1;
    lat = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (ack[2] === 1'b1) lat++;
    end
    stb[2] = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ack[2] === 1'b1) lat++;
    end
    cyc[2] = 1'b0; we = 1'b0;
    check("abort_no_ack", lat, 0);
    xact(2, 1'b0, 4, 0, rd);
    check("abort_no_write", rd, 16'h00AA);
    xact(2, 1'b0, 3, 0, rd);

    // Reset asserted during WAIT.
    xact(2, 1'b1, 5, 16'h0077, rd);
    xact(2, 1'b0, 5, 0, rd);
    xact(2, 1'b1, 0, 1, rd);
    xact(2, 1'b1, 2, 1, rd);
    check("pre_reset_irq", int'(irq[2]), 1);
    adr = 32'(Base + 6); wdat = 16'h5555; we = 1'b1; cyc[2] = 1'b1; stb[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_ack", int'(ack[2]), 0);
    check("rst_dat", rd_of(2), 0);
    check("rst_irq", int'(irq[2]), 0);
    @(posedge clk);
    #1;
    cyc[2] = 1'b0; stb[2] = 1'b0; we = 1'b0;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("post_rst_ack", int'(ack[2]), 0);
    for (int r = 0; r < 8; r++) begin
      xact(2, 1'b0, r, 0, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
